// File: rtl/ieee_to_fp_11_18_pkg.sv
// Shared definitions for the binary64 -> FloPoCo 11_18 operand feeder:
// IEEE field positions, exception codes and the FloPoCo word layout.
package ieee_to_fp_11_18_pkg;

  localparam int unsigned WE           = 11;
  localparam int unsigned BIAS         = 1023;
  localparam int unsigned IEEE_W       = 64;
  localparam int unsigned IEEE_SIGN    = 63;
  localparam int unsigned IEEE_EXP_LSB = 52;
  localparam int unsigned IEEE_FRAC_W  = 52;
  localparam int unsigned FP_WF        = 18;
  localparam int unsigned FP_W         = FP_WF + WE + 3;

  typedef enum logic [1:0] {
    EXN_ZERO = 2'b00,
    EXN_NORM = 2'b01,
    EXN_INF  = 2'b10,
    EXN_NAN  = 2'b11
  } exn_e;

  // exn [31:30], sign [29], exponent [28:18], fraction [17:0]
  typedef struct packed {
    exn_e             exn;
    logic             sign;
    logic [WE-1:0]    exp;
    logic [FP_WF-1:0] frac;
  } fp_11_18_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment of a truncated fraction; carry flags
// a fraction overflow that the caller folds into the exponent.
module fp_round_rne #(
  parameter int unsigned WF = 18
) (
  input  logic [WF-1:0] keep_i,
  input  logic          guard_i,
  input  logic          sticky_i,
  output logic          carry_o,
  output logic [WF-1:0] frac_o
);

  logic round_up;

  assign round_up           = guard_i & (sticky_i | keep_i[0]);
  assign {carry_o, frac_o}  = {1'b0, keep_i} + (WF+1)'(round_up);

endmodule

// File: rtl/ieee_to_fp_11_18.sv
// Streaming binary64 -> FloPoCo 11_18 converter: stage 1 decodes and
// classifies, stage 2 rounds and packs; saturating status counters.
module ieee_to_fp_11_18
  import ieee_to_fp_11_18_pkg::*;
#(
  parameter int unsigned WF    = 18,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WF+13:0]    out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  subnorm_cnt,
  output logic [CNT_W-1:0]  inexact_cnt
);

  localparam int unsigned OW = WF + 14;

  logic                   s1_adv, acc;
  logic [WE-1:0]          e_in;
  logic [IEEE_FRAC_W-1:0] f_in;
  logic [WF-1:0]          keep_in;
  logic                   guard_in, sticky_in, subnorm_in, inexact_in;
  exn_e                   cls_in;

  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_sign_q, s1_sign_d;
  logic [WE-1:0]          s1_exp_q, s1_exp_d;
  exn_e                   s1_cls_q, s1_cls_d;
  logic [WF-1:0]          s1_keep_q, s1_keep_d;
  logic                   s1_guard_q, s1_guard_d;
  logic                   s1_sticky_q, s1_sticky_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [OW-1:0]          out_data_q, out_data_d;
  logic [CNT_W-1:0]       sub_q, sub_d, inx_q, inx_d;

  logic                   rnd_carry;
  logic [WF-1:0]          rnd_frac;
  logic [WE-1:0]          exp_norm;
  logic [OW-1:0]          pack_c;

  assign e_in      = in_data[IEEE_SIGN-1:IEEE_EXP_LSB];
  assign f_in      = in_data[IEEE_FRAC_W-1:0];
  assign keep_in   = f_in[IEEE_FRAC_W-1 -: WF];
  assign guard_in  = f_in[IEEE_FRAC_W-1-WF];
  assign sticky_in = |f_in[IEEE_FRAC_W-2-WF:0];

  assign s1_adv    = !s2_valid_q | out_ready;
  assign in_ready  = !s1_valid_q | s1_adv;
  assign acc       = in_valid & in_ready;
  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign subnorm_cnt = sub_q;
  assign inexact_cnt = inx_q;

  // Input classification; subnormals are flushed to zero
  always_comb begin
    cls_in = EXN_NORM;
    if (e_in == '0)
      cls_in = EXN_ZERO;
    else if (e_in == '1)
      cls_in = (f_in == '0) ? EXN_INF : EXN_NAN;
  end

  assign subnorm_in = (e_in == '0) && (f_in != '0);
  assign inexact_in = (cls_in == EXN_NORM) && (guard_in | sticky_in);

  fp_round_rne #(.WF(WF)) u_round (
    .keep_i   (s1_keep_q),
    .guard_i  (s1_guard_q),
    .sticky_i (s1_sticky_q),
    .carry_o  (rnd_carry),
    .frac_o   (rnd_frac)
  );

  // Exponent 2046 with carry becomes 2047 and stays normal in FloPoCo
  assign exp_norm = s1_exp_q + WE'(rnd_carry);

  always_comb begin
    pack_c = {s1_cls_q, s1_sign_q, WE'(0), WF'(0)};
    if (s1_cls_q == EXN_NORM)
      pack_c = {EXN_NORM, s1_sign_q, exp_norm, rnd_frac};
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_exp_d    = s1_exp_q;
    s1_cls_d    = s1_cls_q;
    s1_keep_d   = s1_keep_q;
    s1_guard_d  = s1_guard_q;
    s1_sticky_d = s1_sticky_q;
    s2_valid_d  = s2_valid_q;
    out_data_d  = out_data_q;
    sub_d       = sub_q;
    inx_d       = inx_q;

    if (in_ready)
      s1_valid_d = in_valid;
    if (acc) begin
      s1_sign_d   = in_data[IEEE_SIGN];
      s1_exp_d    = e_in;
      s1_cls_d    = cls_in;
      s1_keep_d   = keep_in;
      s1_guard_d  = guard_in;
      s1_sticky_d = sticky_in;
    end

    if (s1_adv)
      s2_valid_d = s1_valid_q;
    if (s1_adv && s1_valid_q)
      out_data_d = pack_c;

    // Clear wins over a same-cycle increment
    if (cnt_clr) begin
      sub_d = '0;
      inx_d = '0;
    end else if (acc) begin
      if (subnorm_in && (sub_q != '1))
        sub_d = sub_q + CNT_W'(1);
      if (inexact_in && (inx_q != '1))
        inx_d = inx_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_cls_q    <= EXN_ZERO;
      s1_keep_q   <= '0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_data_q  <= '0;
      sub_q       <= '0;
      inx_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_exp_q    <= s1_exp_d;
      s1_cls_q    <= s1_cls_d;
      s1_keep_q   <= s1_keep_d;
      s1_guard_q  <= s1_guard_d;
      s1_sticky_q <= s1_sticky_d;
      s2_valid_q  <= s2_valid_d;
      out_data_q  <= out_data_d;
      sub_q       <= sub_d;
      inx_q       <= inx_d;
    end
  end

endmodule

// File: tb/tb_ieee_to_fp_11_18.sv
// Randomized and directed bench for ieee_to_fp_11_18 against an
// arithmetic reference model with a scoreboard queue.
module tb_ieee_to_fp_11_18;

  localparam int unsigned CNT_MAX = 65535;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        cnt_clr;
  logic [15:0] subnorm_cnt;
  logic [15:0] inexact_cnt;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  int unsigned m_sub = 0;
  int unsigned m_inx = 0;
  logic        obs_valid, obs_ready, last_acc;

  always #5 clk = ~clk;

  ieee_to_fp_11_18 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .cnt_clr     (cnt_clr),
    .subnorm_cnt (subnorm_cnt),
    .inexact_cnt (inexact_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: truncate to 18 bits, round half to even by comparing the
  // discarded 34 bits against one half ulp.
  function automatic logic [31:0] ref_conv(input logic [63:0] x);
    logic            s;
    int unsigned     e;
    longint unsigned f, mant, rem, half;
    s    = x[63];
    e    = 32'(x[62:52]);
    f    = 64'(x[51:0]);
    half = 64'd1 << 33;
    if (e == 0) return {2'b00, s, 29'd0};
    if (e == 2047) return (f == 0) ? {2'b10, s, 29'd0} : {2'b11, s, 29'd0};
    mant = f >> 34;
    rem  = f % (64'd1 << 34);
    if (rem > half || (rem == half && (mant % 2) == 1)) mant++;
    if (mant == (64'd1 << 18)) begin
      mant = 0;
      e++;
    end
    return {2'b01, s, e[10:0], mant[17:0]};
  endfunction

  function automatic bit ref_subnorm(input logic [63:0] x);
    return (x[62:52] == 11'd0) && (x[51:0] != 52'd0);
  endfunction

  function automatic bit ref_inexact(input logic [63:0] x);
    bit normal;
    normal = (x[62:52] != 11'd0) && (x[62:52] != 11'h7FF);
    return normal && ((64'(x[51:0]) % (64'd1 << 34)) != 0);
  endfunction

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: begin w[62:52] = 11'd0;    if ($urandom_range(0, 1) == 0) w[51:0] = 52'd0; end
      1: begin w[62:52] = 11'h7FF;  if ($urandom_range(0, 1) == 0) w[51:0] = 52'd0; end
      2: begin w[62:52] = 11'h7FE;  w[51:34] = 18'h3FFFF; end
      3: w[33:0] = 34'h200000000;
      default: ;
    endcase
    return w;
  endfunction

  // One clock: drive, sample mid-cycle, then advance scoreboard and model
  task automatic step(input logic v, input logic [63:0] d, input logic [31:0] exp,
                      input logic ordy, input logic clr);
    logic acc, deq;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    cnt_clr   = clr;
    #1;
    obs_valid = out_valid;
    obs_ready = in_ready;
    if (out_valid) begin
      if (exp_q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
      else                   chk("out_data", 64'(out_data), 64'(exp_q[0]));
    end
    chk("subnorm_cnt", 64'(subnorm_cnt), 64'(m_sub));
    chk("inexact_cnt", 64'(inexact_cnt), 64'(m_inx));
    acc      = v & in_ready;
    deq      = out_valid & ordy;
    last_acc = acc;
    @(posedge clk);
    if (deq && exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(exp);
    if (clr) begin
      m_sub = 0;
      m_inx = 0;
    end else if (acc) begin
      if (ref_subnorm(d) && m_sub < CNT_MAX) m_sub++;
      if (ref_inexact(d) && m_inx < CNT_MAX) m_inx++;
    end
  endtask

  logic [63:0] dir_in  [8] = '{64'h3FF0000000000000, 64'h3FF0000200000000,
                               64'h3FF0000600000000, 64'h3FFFFFFFFFFFFFFF,
                               64'h8000000000000000, 64'h0000000000000001,
                               64'h7FF0000000000000, 64'h7FF8000000000000};
  logic [31:0] dir_out [8] = '{32'h4FFC0000, 32'h4FFC0000, 32'h4FFC0002, 32'h50000000,
                               32'h20000000, 32'h00000000, 32'h80000000, 32'hC0000000};
  logic [63:0] bp_w [4];

  initial begin
    int idx;
    logic [63:0] w;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_subnorm", 64'(subnorm_cnt), 64'd0);
    chk("rst_inexact", 64'(inexact_cnt), 64'd0);
    rst = 1'b0;

    // Latency of 1.0 with out_ready high
    step(1'b1, dir_in[0], dir_out[0], 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("lat_cycle1", 64'(obs_valid), 64'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("lat_cycle2", 64'(obs_valid), 64'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("inexact_after_1p0", 64'(inexact_cnt), 64'd0);

    // Directed rounding and special values, spec-given expectations
    for (int i = 1; i < 8; i++) step(1'b1, dir_in[i], dir_out[i], 1'b1, 1'b0);
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("dir_inexact", 64'(inexact_cnt), 64'd3);
    chk("dir_subnorm", 64'(subnorm_cnt), 64'd1);

    // Backpressure: 4 offered words, only 2 fit while stalled
    for (int i = 0; i < 4; i++) bp_w[i] = rand_word();
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      step(idx < 4, bp_w[idx < 4 ? idx : 0], ref_conv(bp_w[idx < 4 ? idx : 0]), 1'b0, 1'b0);
      if (last_acc) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'd2);
    chk("bp_in_ready", 64'(obs_ready), 64'd0);
    for (int c = 0; c < 20 && (idx < 4 || exp_q.size() > 0); c++) begin
      step(idx < 4, bp_w[idx < 4 ? idx : 0], ref_conv(bp_w[idx < 4 ? idx : 0]), 1'b1, 1'b0);
      if (last_acc) idx++;
    end
    chk("bp_all_in", 64'(idx), 64'd4);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      w = rand_word();
      step($urandom_range(0, 9) < 7, w, ref_conv(w), $urandom_range(0, 9) < 7,
           $urandom_range(0, 199) == 0);
    end

    // Saturation then clear with a colliding subnormal
    step(1'b0, '0, '0, 1'b1, 1'b1);
    for (int c = 0; c < 65540; c++) step(1'b1, 64'h1, 32'h0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("sub_saturated", 64'(subnorm_cnt), 64'hFFFF);
    step(1'b1, 64'h1, 32'h0, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("sub_clr_wins", 64'(subnorm_cnt), 64'd0);
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Reset with both stages full
    for (int c = 0; c < 4; c++) step(1'b1, 64'h1, 32'h0, 1'b0, 1'b0);
    chk("pre_rst_sub", 64'(subnorm_cnt), 64'd2);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_out_data", 64'(out_data), 64'd0);
    chk("async_subnorm", 64'(subnorm_cnt), 64'd0);
    chk("async_inexact", 64'(inexact_cnt), 64'd0);
    exp_q.delete();
    m_sub = 0;
    m_inx = 0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, dir_in[2], dir_out[2], 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("post_rst_c1", 64'(obs_valid), 64'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("post_rst_c2", 64'(obs_valid), 64'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("post_rst_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ieee_to_fp_11_18.md
Name: ieee_to_fp_11_18

Overview:
- Streaming operand feeder that converts IEEE-754 binary64 values into the 32-bit FloPoCo 11_18 format.
- Its output is the format consumed by the FPSub_11_18_F400_uid2-based comparators in the ray/AABB datapath.
- 2-stage pipeline with valid/ready handshake on both sides.
- Saturating counters for flushed subnormals and inexact (rounded) conversions.

Parameters:
- WF, 18, output fraction width (exponent fixed at 11, bias 1023, same as binary64).
- CNT_W, 16, width of the status counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept in_data this cycle
- in_data  in  64  IEEE binary64: sign [63], exponent [62:52], fraction [51:0]
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  WF+14  FloPoCo word: exn [31:30] (00 zero, 01 normal, 10 inf, 11 NaN), sign [29], exponent [28:18], fraction [17:0]
- cnt_clr  in  1  synchronous clear of both counters
- subnorm_cnt  out  CNT_W  subnormal inputs flushed to zero, saturating
- inexact_cnt  out  CNT_W  normal inputs whose discarded fraction bits were nonzero, saturating

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, both counters=0. Reset mid-stream discards in-flight words.
- Handshake:
  - A transfer occurs when valid & ready are both high.
  - s1_adv = !s2_valid | out_ready.
  - in_ready = !s1_valid | s1_adv; this is a combinational path from out_ready.
  - out_valid = s2_valid.
  - out_data holds steady while out_valid & !out_ready.
- Latency: 2 cycles from an accepted input to out_valid with out_ready held high. Throughput is 1 word/cycle. Order is preserved and no word is lost or duplicated.
- Stage 1 (decode + round decision), registered:
  - E = in_data[62:52]; F = in_data[51:0].
  - keep = F[51:52-WF]; guard = F[51-WF]; sticky = OR of F[50-WF:0].
  - round_up = guard & (sticky | keep[0]), i.e. round-to-nearest-even.
  - class:
    - E=0 gives zero. F!=0 is a subnormal, which flushes to zero.
    - E=2047 with F=0 gives inf.
    - E=2047 with F!=0 gives NaN.
    - Otherwise normal.
- Stage 2 (pack), registered:
  - normal: exn=01, sign=in sign.
    - {carry, frac} = keep + round_up.
    - exponent = E + carry; frac=0 when carry.
    - E=2046 with carry gives exponent 2047, still normal. FloPoCo has no reserved exponent code.
  - zero: exn=00, sign kept, exponent=0, frac=0.
  - inf: exn=10, sign kept, exponent=0, frac=0.
  - NaN: exn=11, sign kept, exponent=0, frac=0.
- Counters:
  - Update when a word is accepted into stage 1.
  - subnorm_cnt += 1 when E=0 and F!=0.
  - inexact_cnt += 1 when class is normal and (guard | sticky).
  - Both saturate at all-ones.
  - cnt_clr has priority over the increment in the same cycle, giving 0.

Decomposition:
- Shared package holds:
  - exn codes EXN_ZERO=2'b00, EXN_NORM=2'b01, EXN_INF=2'b10, EXN_NAN=2'b11
  - IEEE field positions, bias 1023, WE=11
  - the FloPoCo word layout
- One sub-module, fp_round_rne: combinational; takes keep, guard, sticky and outputs {carry, frac}. It is reused by a later FloPoCo-to-binary32 path.
- Pipeline control, class decode and counters stay in the top.

Test Plan:
- 1.0 (0x3FF0000000000000), out_ready=1 -> out_data=0x4FFC0000 exactly 2 cycles after acceptance; inexact_cnt unchanged.
- Rounding:
  - tie to even 0x3FF0000200000000 -> 0x4FFC0000, inexact_cnt+1.
  - tie with odd lsb 0x3FF0000600000000 -> 0x4FFC0002, inexact_cnt+1.
  - mantissa carry 0x3FFFFFFFFFFFFFFF -> 0x50000000.
- Specials:
  - -0.0 (0x8000000000000000) -> 0x20000000.
  - subnormal 0x0000000000000001 -> 0x00000000, subnorm_cnt=1.
  - +inf 0x7FF0000000000000 -> 0x80000000.
  - NaN 0x7FF8000000000000 -> 0xC0000000.
- Backpressure: offer 4 back-to-back words with out_ready=0 -> in_ready drops after 2 accepted; out_data stable; release out_ready -> all 4 emerge in order, no gaps or duplicates.
- Saturation and clear: preload via 2^CNT_W subnormals -> subnorm_cnt sticks at 0xFFFF; cnt_clr together with a subnormal input -> 0.
- Reset mid-stream: assert rst with both stages full -> out_valid=0 and counters=0 immediately (asynchronous); first post-reset input emerges after 2 cycles.
